// File: rtl/mini_rv32i_mmio_pkg.sv
// Shared constants and types for the mini_rv32i MMIO slave: register offsets, FSM states, default window base.
// The optional CYCLE register (offset OFF_CYCLE) is only decoded when MINI_RV32I_MMIO_CYCLE_CNT_EN is defined.
package mini_rv32i_mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    localparam logic [7:0] OFF_IN_A  = 8'h00;
    localparam logic [7:0] OFF_IN_B  = 8'h04;
    localparam logic [7:0] OFF_OP    = 8'h08;
    localparam logic [7:0] OFF_RES   = 8'h0C;
    localparam logic [7:0] OFF_DONE  = 8'h10;
    localparam logic [7:0] OFF_CYCLE = 8'h14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/mini_rv32i_mmio_if.sv
// Load/store bus between the mini_rv32i core (master) and an MMIO slave.
interface mini_rv32i_mmio_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_rdata, bus_ready, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_rdata, bus_ready, bus_err
    );
endinterface

// File: rtl/mini_rv32i_mmio_byte_merge.sv
// Per-byte merge of a stored word into existing data under a write strobe.
// Purely combinational so it can be shared with a RAM slave.
module mmio_byte_merge (
    input  logic [31:0] old_data_i,
    input  logic [31:0] new_data_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] merged_o
);

    // Select each byte from the new word where its strobe is set.
    always_comb begin
        merged_o = old_data_i;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_i[i]) begin
                merged_o[8*i +: 8] = new_data_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_data_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mini_rv32i_mmio.sv
// MMIO slave for the mini_rv32i core: read-only operand snapshot, result and done registers.
// Define MINI_RV32I_MMIO_CYCLE_CNT_EN to add the free-running CYCLE register at offset 0x14.
module mini_rv32i_mmio
    import mini_rv32i_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mini_rv32i_mmio_if.slave      bus,
    input  logic [DATA_W-1:0]     io_in_a,
    input  logic [DATA_W-1:0]     io_in_b,
    input  logic [1:0]            io_op,
    output logic [DATA_W-1:0]     io_out_res,
    output logic                  io_out_valid,
    output logic                  done
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [31:0] res_q, res_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] dec_addr_s;
    logic        mapped_s;
    logic [31:0] rd_val_s;
    logic        dec_err_s;
    logic [31:0] merged_s;

`ifdef MINI_RV32I_MMIO_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Cycle counter runs until firmware signals done, wrapping naturally.
    always_comb begin
        if (!done_q) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end
`endif

    mmio_byte_merge u_merge (
        .old_data_i (res_q),
        .new_data_i (wdata_q),
        .wstrb_i    (wstrb_q),
        .merged_o   (merged_s)
    );

    // Decode the live address when accepting, the latched one when committing.
    always_comb begin
        if (state_q == ST_IDLE) begin
            dec_addr_s = bus.bus_addr;
        end else begin
            dec_addr_s = addr_q;
        end
        mapped_s = 1'b1;
        case (dec_addr_s[7:0])
            OFF_IN_A:  rd_val_s = a_q;
            OFF_IN_B:  rd_val_s = b_q;
            OFF_OP:    rd_val_s = {30'b0, op_q};
            OFF_RES:   rd_val_s = res_q;
            OFF_DONE:  rd_val_s = {31'b0, done_q};
`ifdef MINI_RV32I_MMIO_CYCLE_CNT_EN
            OFF_CYCLE: rd_val_s = cyc_q;
`endif
            default: begin
                rd_val_s = 32'h0000_0000;
                mapped_s = 1'b0;
            end
        endcase
        dec_err_s = (dec_addr_s[31:8] != BASE_ADDR[31:8]) ||
                    (dec_addr_s[1:0] != 2'b00) || !mapped_s;
    end

    // Two-state access FSM: accept and answer in IDLE, pulse ready and commit in RESP.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        res_d   = res_q;
        valid_d = valid_q;
        done_d  = done_q;
        rdata_d = 32'h0000_0000;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.bus_req) begin
                    state_d = ST_RESP;
                    we_d    = bus.bus_we;
                    addr_d  = bus.bus_addr;
                    wdata_d = bus.bus_wdata;
                    wstrb_d = bus.bus_wstrb;
                    ready_d = 1'b1;
                    err_d   = dec_err_s;
                    if (!bus.bus_we && !dec_err_s) begin
                        rdata_d = rd_val_s;
                    end else begin
                        rdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (we_q && !dec_err_s) begin
                    // Result is frozen once done is set so an external checker sees a stable value.
                    if (addr_q[7:0] == OFF_RES && !done_q && wstrb_q != 4'h0) begin
                        res_d   = merged_s;
                        valid_d = 1'b1;
                    end else if (addr_q[7:0] == OFF_DONE && wdata_q[0] && wstrb_q[0]) begin
                        done_d = 1'b1;
                    end else begin
                        res_d  = res_q;
                    end
                end else begin
                    res_d = res_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also snapshots the operand pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'h0;
            a_q     <= io_in_a;
            b_q     <= io_in_b;
            op_q    <= io_op;
            res_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MINI_RV32I_MMIO_CYCLE_CNT_EN
            cyc_q   <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef MINI_RV32I_MMIO_CYCLE_CNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    // Masking with rst keeps every output at zero for the whole reset cycle,
    // including a RESP cycle cut short by reset.
    assign bus.bus_ready = ready_q & ~rst;
    assign bus.bus_err   = err_q & ~rst;
    assign bus.bus_rdata = rdata_q & {32{~rst}};
    assign io_out_res    = res_q & {32{~rst}};
    assign io_out_valid  = valid_q & ~rst;
    assign done          = done_q & ~rst;

endmodule

// File: tb/tb_mini_rv32i_mmio.sv
// Directed self-checking bench for mini_rv32i_mmio; expected values are hand-computed constants.
module tb_mini_rv32i_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_in_a;
    logic [31:0] io_in_b;
    logic [1:0]  io_op;
    logic [31:0] io_out_res;
    logic        io_out_valid;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    mini_rv32i_mmio_if bus ();

    mini_rv32i_mmio dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .io_in_a      (io_in_a),
        .io_in_b      (io_in_b),
        .io_op        (io_op),
        .io_out_res   (io_out_res),
        .io_out_valid (io_out_valid),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus access; returns data, error and the number of edges until ready (0 = timeout).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clk);
        bus.bus_req   = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        bus.bus_wstrb = wstrb;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (lat == 0) begin
                @(posedge clk);
                #1;
                if (bus.bus_ready) begin
                    lat   = i;
                    rdata = bus.bus_rdata;
                    err   = bus.bus_err;
                end
            end
        end
        bus.bus_req = 1'b0;
        bus.bus_we  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(1'b0, addr, 32'h0, 4'h0, rd, er, lat);
        check_eq({tag, "_lat"}, lat, 32'd1);
        check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check_eq({tag, "_data"}, rd, exp_data);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(1'b1, addr, data, strb, rd, er, lat);
        check_eq({tag, "_lat"}, lat, 32'd1);
        check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check_eq({tag, "_rdata"}, rd, 32'h0);
    endtask

    task automatic apply_reset(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        @(negedge clk);
        io_in_a = a;
        io_in_b = b;
        io_op   = op;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic        e1;
        int          l1;

        rst           = 1'b1;
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;
        bus.bus_wstrb = 4'h0;
        io_in_a       = 32'd0;
        io_in_b       = 32'd0;
        io_op         = 2'd0;

        // Reset state and operand snapshot
        @(negedge clk);
        io_in_a = 32'd21;
        io_in_b = 32'd9;
        io_op   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, bus.bus_ready}, 32'd0);
        check_eq("rst_err",   {31'b0, bus.bus_err}, 32'd0);
        check_eq("rst_rdata", bus.bus_rdata, 32'd0);
        check_eq("rst_res",   io_out_res, 32'd0);
        check_eq("rst_valid", {31'b0, io_out_valid}, 32'd0);
        check_eq("rst_done",  {31'b0, done}, 32'd0);
        apply_reset(32'd21, 32'd9, 2'd0);
        io_in_a = 32'd0;
        io_in_b = 32'd0;
        io_op   = 2'd3;
        do_load("in_a", 32'h1000_0000, 32'd21, 1'b0);
        do_load("in_b", 32'h1000_0004, 32'd9, 1'b0);
        do_load("op",   32'h1000_0008, 32'd0, 1'b0);
        check_eq("idle_rdata", bus.bus_rdata, 32'd0);

        // Decode and alignment errors
        do_load("misalign", 32'h1000_0002, 32'd0, 1'b1);
        do_load("outside",  32'h2000_0000, 32'd0, 1'b1);
        do_load("unmapped", 32'h1000_0018, 32'd0, 1'b1);
        do_store("err_st", 32'h2000_000C, 32'h1234_5678, 4'hF, 1'b1);
        check_eq("err_st_res",   io_out_res, 32'd0);
        check_eq("err_st_valid", {31'b0, io_out_valid}, 32'd0);
        do_store("ro_st", 32'h1000_0000, 32'h0000_AAAA, 4'hF, 1'b0);
        do_load("ro_chk", 32'h1000_0000, 32'd21, 1'b0);

        // Byte-strobe merge into RES
        do_store("res_hi", 32'h1000_000C, 32'hFFFF_0000, 4'hF, 1'b0);
        check_eq("res_hi_val", io_out_res, 32'hFFFF_0000);
        check_eq("res_valid",  {31'b0, io_out_valid}, 32'd1);
        do_store("res_lo", 32'h1000_000C, 32'h0000_FFFF, 4'h3, 1'b0);
        check_eq("res_lo_val", io_out_res, 32'hFFFF_FFFF);
        do_store("res_b2", 32'h1000_000C, 32'h1234_5678, 4'h4, 1'b0);
        check_eq("res_b2_val", io_out_res, 32'hFF34_FFFF);
        do_load("res_rd", 32'h1000_000C, 32'hFF34_FFFF, 1'b0);

        // Result then DONE; RES frozen afterwards
        do_store("res_1e", 32'h1000_000C, 32'h0000_001E, 4'hF, 1'b0);
        check_eq("res_1e_val", io_out_res, 32'h0000_001E);
        do_store("done_w0", 32'h1000_0010, 32'h0000_0000, 4'h1, 1'b0);
        check_eq("done_w0_val", {31'b0, done}, 32'd0);
        do_store("done_nostrb", 32'h1000_0010, 32'h0000_0001, 4'h2, 1'b0);
        check_eq("done_nostrb_val", {31'b0, done}, 32'd0);
        do_store("done_w1", 32'h1000_0010, 32'h0000_0001, 4'h1, 1'b0);
        check_eq("done_set", {31'b0, done}, 32'd1);
        do_load("done_rd", 32'h1000_0010, 32'd1, 1'b0);
        do_store("res_frozen", 32'h1000_000C, 32'h0000_DEAD, 4'hF, 1'b0);
        check_eq("res_frozen_val", io_out_res, 32'h0000_001E);
        check_eq("valid_hold",     {31'b0, io_out_valid}, 32'd1);
        check_eq("done_hold",      {31'b0, done}, 32'd1);

        // Optional cycle counter
        apply_reset(32'd1, 32'd2, 2'd1);
`ifdef MINI_RV32I_MMIO_CYCLE_CNT_EN
        repeat (100) @(posedge clk);
        do_store("cyc_done", 32'h1000_0010, 32'h0000_0001, 4'h1, 1'b0);
        access(1'b0, 32'h1000_0014, 32'h0, 4'h0, r1, e1, l1);
        check_eq("cyc_rd1_err", {31'b0, e1}, 32'd0);
        access(1'b0, 32'h1000_0014, 32'h0, 4'h0, r2, e1, l1);
        check_eq("cyc_rd2_err", {31'b0, e1}, 32'd0);
        check_eq("cyc_frozen", r2, r1);
        check_eq("cyc_range", {31'b0, (r1 >= 32'd100 && r1 <= 32'd106)}, 32'd1);
`else
        do_load("cyc_unmapped", 32'h1000_0014, 32'd0, 1'b1);
`endif

        // Reset during the RESP cycle of a RES store
        apply_reset(32'd7, 32'd8, 2'd2);
        @(negedge clk);
        bus.bus_req   = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = 32'h1000_000C;
        bus.bus_wdata = 32'h0000_0055;
        bus.bus_wstrb = 4'hF;
        @(posedge clk);
        #1;
        check_eq("mid_pre_ready", {31'b0, bus.bus_ready}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_ready", {31'b0, bus.bus_ready}, 32'd0);
        bus.bus_req = 1'b0;
        bus.bus_we  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_res",   io_out_res, 32'd0);
        check_eq("mid_valid", {31'b0, io_out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_res",   io_out_res, 32'd0);
        check_eq("post_valid", {31'b0, io_out_valid}, 32'd0);
        do_load("post_op", 32'h1000_0008, 32'd2, 1'b0);
        do_load("post_res_rd", 32'h1000_000C, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
